// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard controller: shadow scoreboard, forwarding selects, stalls, flush.
// Optional: FORWARDING_EN enables operand forwarding; otherwise producers stall consumers.
module exe_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src2,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             hazard,
  output logic             id_bubble,
  output logic             flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] dest;
  } shadow_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } state_t;

  // The WB occupant is never consulted (written early in WB), so only EXE/MEM are kept.
  shadow_t exe_q, mem_q, id_ent;
  state_t  state, prior;

  logic m1_exe, m1_mem, m2_exe, m2_mem;
  logic stall_src, accept;
  logic [1:0] nxt_sel1, nxt_sel2;
  logic unused;

  assign m1_exe = exe_q.valid & exe_q.wb_en & (exe_q.dest == id_src1);
  assign m1_mem = mem_q.valid & mem_q.wb_en & (mem_q.dest == id_src1);
  assign m2_exe = id_use_src2 & exe_q.valid & exe_q.wb_en &
                  (exe_q.dest == id_src2);
  assign m2_mem = id_use_src2 & mem_q.valid & mem_q.wb_en &
                  (mem_q.dest == id_src2);

`ifdef FORWARDING_EN
  assign stall_src = (m1_exe | m2_exe) & exe_q.mem_r_en;

  always_comb begin
    nxt_sel1 = 2'b00;
    nxt_sel2 = 2'b00;
    if (m1_exe & !exe_q.mem_r_en) nxt_sel1 = 2'b01;
    else if (m1_mem)              nxt_sel1 = 2'b10;
    if (m2_exe & !exe_q.mem_r_en) nxt_sel2 = 2'b01;
    else if (m2_mem)              nxt_sel2 = 2'b10;
  end
`else
  assign stall_src = m1_exe | m2_exe | m1_mem | m2_mem;
  assign nxt_sel1  = 2'b00;
  assign nxt_sel2  = 2'b00;
`endif

  assign unused      = exe_q.mem_r_en ^ mem_q.mem_r_en;
  assign pipe_freeze = mem_busy;
  assign flush       = branch_taken & !mem_busy;
  assign hazard      = id_valid & stall_src & !flush & !mem_busy;
  assign id_bubble   = hazard | flush;
  assign accept      = id_valid & !hazard & !flush;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = 1'b1;
    id_ent.wb_en    = id_wb_en;
    id_ent.mem_r_en = id_mem_r_en;
    id_ent.dest     = id_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q    <= '0;
      mem_q    <= '0;
      sel_src1 <= 2'b00;
      sel_src2 <= 2'b00;
    end else if (!mem_busy) begin
      mem_q    <= exe_q;
      exe_q    <= accept ? id_ent : '0;
      sel_src1 <= accept ? nxt_sel1 : 2'b00;
      sel_src2 <= accept ? nxt_sel2 : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((hazard | mem_busy) && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      prior <= RUN;
    end else if (mem_busy) begin
      if (state != MEM_WAIT) begin
        prior <= state;
        state <= MEM_WAIT;
      end
    end else begin
      case (state)
        RUN:      if (hazard) state <= LU_STALL;
        LU_STALL: state <= RUN;
        MEM_WAIT: state <= prior;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: cycle vector table plus sel scoreboard queue.
// Expectations follow FORWARDING_EN when it is defined.
module tb_exe_hazard_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_src2, id_wb_en, id_mem_r_en;
  logic [3:0]    id_src1, id_src2, id_dest;
  logic          branch_taken, mem_busy;
  logic [1:0]    sel_src1, sel_src2;
  logic          hazard, id_bubble, flush, pipe_freeze;
  logic [CW-1:0] stall_cnt;

  exe_hazard_ctrl #(.REG_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .hazard(hazard), .id_bubble(id_bubble), .flush(flush),
    .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [3:0] s1, s2;
    logic       u, wb, ld;
    logic [3:0] d;
    logic       br, busy;
    logic       eh, ef, acc;
    logic [1:0] e1, e2;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cnt_exp = 0;
  logic [1:0] last1 = 2'b00;
  logic [1:0] last2 = 2'b00;

  function automatic vec_t mk(int v, int s1, int s2, int u, int wb,
                              int ld, int d, int br, int busy,
                              int eh, int ef, int acc, int e1, int e2);
    vec_t r;
    r.vld = v[0];    r.s1 = s1[3:0];  r.s2 = s2[3:0];
    r.u = u[0];      r.wb = wb[0];    r.ld = ld[0];
    r.d = d[3:0];    r.br = br[0];    r.busy = busy[0];
    r.eh = eh[0];    r.ef = ef[0];    r.acc = acc[0];
    r.e1 = e1[1:0];  r.e2 = e2[1:0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid     = t.vld;
    id_src1      = t.s1;
    id_src2      = t.s2;
    id_use_src2  = t.u;
    id_wb_en     = t.wb;
    id_mem_r_en  = t.ld;
    id_dest      = t.d;
    branch_taken = t.br;
    mem_busy     = t.busy;
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [3:0] e;
    drive(t);
    #2;
    chk($sformatf("hazard[%0d]", idx), int'(hazard), int'(t.eh));
    chk($sformatf("flush[%0d]", idx), int'(flush), int'(t.ef));
    chk($sformatf("bubble[%0d]", idx), int'(id_bubble),
        int'(t.eh | t.ef));
    chk($sformatf("freeze[%0d]", idx), int'(pipe_freeze),
        int'(t.busy));
    if (t.busy) begin
      chk($sformatf("hold_sel1[%0d]", idx), int'(sel_src1), int'(last1));
      chk($sformatf("hold_sel2[%0d]", idx), int'(sel_src2), int'(last2));
    end
    if (t.acc) sbq.push_back({t.e1, t.e2});
    @(posedge clk);
    #1;
    if ((t.eh || t.busy) && cnt_exp < (1 << CW) - 1) cnt_exp++;
    chk($sformatf("stall_cnt[%0d]", idx), int'(stall_cnt), cnt_exp);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      last1 = e[3:2];
      last2 = e[1:0];
      chk($sformatf("sel_src1[%0d]", idx), int'(sel_src1), int'(e[3:2]));
      chk($sformatf("sel_src2[%0d]", idx), int'(sel_src2), int'(e[1:0]));
    end
  endtask

  initial begin
`ifdef FORWARDING_EN
    vecs.push_back(mk(1, 2, 3, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 0, 2, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 0, 1, 2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 6, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 7, 0, 1, 1, 0, 8, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 7, 0, 1, 1, 0, 8, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(1, 3, 8, 0, 1, 0, 10, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 10, 8, 1, 1, 0, 11, 0, 0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 11, 0, 1, 1, 0, 9, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 9, 1, 0, 0, 12, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 12, 2, 1, 1, 0, 13, 0, 0, 0, 0, 1, 0, 2));
`else
    vecs.push_back(mk(1, 2, 3, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 6, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 6, 0, 1, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 6, 0, 1, 1, 0, 7, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6, 0, 1, 1, 0, 7, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3, 7, 0, 1, 0, 10, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 12, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 12, 0, 1, 1, 0, 13, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0));
`endif
    // Trailing freeze saturates the narrow counter; branch during it must not flush.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_sel1", int'(sel_src1), 0);
    chk("rst_sel2", int'(sel_src2), 0);
    chk("rst_hazard", int'(hazard), 0);
    chk("rst_bubble", int'(id_bubble), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_freeze", int'(pipe_freeze), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset in the middle of a load-use stall clears the scoreboard.
    apply(mk(1, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0), 100);
    drive(mk(1, 3, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("pre_rst_hazard", int'(hazard), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_exp = 0;
    #1;
    chk("mid_rst_hazard", int'(hazard), 0);
    chk("mid_rst_cnt", int'(stall_cnt), 0);
    chk("mid_rst_sel1", int'(sel_src1), 0);
    apply(mk(1, 3, 0, 1, 1, 0, 4, 0, 0, 0, 0, 1, 0, 0), 101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
